fetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the IF_ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a request/acknowledge interface with variable latency.
- Buffers returned instructions, each with its PC, in a DEPTH-entry FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; decode stalls by holding ready low.
- Branch redirects from the MEM stage flush the FIFO and any in-flight response.

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle: redirect input, instruction-memory request/ack,
// and the valid/ready decode handshake.
interface fetch_queue_if;
  logic        redirect;
  logic [63:0] redirect_addr;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;

  modport master (
    input  redirect, redirect_addr, imem_ack, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect, redirect_addr, imem_ack, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, keeps at most one memory request
// outstanding, and buffers {pc, instr} pairs for decode.
//
//   state | meaning
//   IDLE  | no request outstanding; an ack here is ignored
//   WAIT  | request outstanding, its response is pushed
//   DROP  | request outstanding, its response is discarded (flushed by redirect)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state, state_next;
  logic [63:0]   fetch_pc, req_pc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push, pop, issue, ack_ok, valid;

  always_comb begin
    valid      = !rst && (count != '0) && !bus.redirect;
    pop        = valid && bus.out_ready;
    push       = !rst && !bus.redirect && (state == WAIT) && bus.imem_ack;
    count_next = count + CW'(push) - CW'(pop);
    // The slot test uses post-push/pop occupancy so an outstanding request
    // always has somewhere to land.
    ack_ok     = (state == IDLE) || bus.imem_ack;
    issue      = !rst && !bus.redirect && ack_ok && (count_next < CW'(DEPTH));
  end

  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = ((state == IDLE) || bus.imem_ack) ? IDLE : DROP;
    end else if (issue) begin
      state_next = WAIT;
    end else if ((state != IDLE) && bus.imem_ack) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_addr & ~64'h3;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= req_pc;
      instr_mem[tail] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = rst ? RESET_PC : fetch_pc;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? instr_mem[head] : 32'h0;
  assign bus.out_pc    = valid ? pc_mem[head] : 64'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: variable-latency memory model, transaction-level
// reference with scoreboard, plus directed scenario tasks.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [95:0] sb[$];
  int          mem_lat  = 1;
  int          mem_left = 0;
  bit          mem_busy = 0;
  logic [63:0] mem_addr = 64'h0;
  logic [63:0] exp_pc   = 64'h0;
  bit          ref_out  = 0;
  bit          ref_keep = 0;

  // Memory responds mem_lat cycles after a request; the monitor half compares
  // DUT outputs against a transaction model one step after the falling edge.
  always @(negedge clk) begin
    bit   ack_s, exp_valid, pop_e, push_e, exp_req;
    int   occ;
    bus.imem_ack   = mem_busy && (mem_left == 1);
    bus.imem_rdata = bus.imem_ack ? (mem_addr[31:0] | 32'hA000_0000) : 32'h0;
    #1;
    ack_s = bus.imem_ack;
    if (rst) begin
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL mon_rst_outs: req=%0b valid=%0b expected 0/0", bus.imem_req, bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.imem_addr !== 64'h0) $display("FAIL mon_rst_addr: got %h expected 0", bus.imem_addr);
      else n_pass++;
      sb.delete();
      ref_out  = 0;
      ref_keep = 0;
      exp_pc   = 64'h0;
    end else begin
      exp_valid = (sb.size() != 0) && !bus.redirect;
      n_checks++;
      if (bus.out_valid !== exp_valid) $display("FAIL mon_valid: got %0b expected %0b at %0t", bus.out_valid, exp_valid, $time);
      else n_pass++;
      if (exp_valid && bus.out_valid) begin
        n_checks++;
        if ({bus.out_pc, bus.out_instr} !== sb[0]) $display("FAIL mon_head: got pc=%h instr=%h expected pc=%h instr=%h", bus.out_pc, bus.out_instr, sb[0][95:32], sb[0][31:0]);
        else n_pass++;
      end
      if (sb.size() == 0) begin
        n_checks++;
        if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) $display("FAIL mon_empty_zero: got pc=%h instr=%h expected 0", bus.out_pc, bus.out_instr);
        else n_pass++;
      end
      pop_e   = exp_valid && bus.out_ready;
      push_e  = ref_out && ref_keep && ack_s && !bus.redirect;
      occ     = sb.size() + int'(push_e) - int'(pop_e);
      exp_req = !bus.redirect && (!ref_out || ack_s) && (occ < DEPTH);
      n_checks++;
      if (bus.imem_req !== exp_req) $display("FAIL mon_req: got %0b expected %0b at %0t", bus.imem_req, exp_req, $time);
      else n_pass++;
      if (pop_e) void'(sb.pop_front());
      if (push_e) sb.push_back({mem_addr, bus.imem_rdata});
      if (ack_s && ref_out) ref_out = 0;
      if (bus.redirect) begin
        sb.delete();
        ref_keep = 0;
        exp_pc   = bus.redirect_addr & ~64'h3;
      end
      if (bus.imem_req) begin
        n_checks++;
        if (bus.imem_addr !== exp_pc) $display("FAIL mon_addr: got %h expected %h", bus.imem_addr, exp_pc);
        else n_pass++;
        exp_pc   = exp_pc + 64'd4;
        ref_out  = 1;
        ref_keep = 1;
      end
    end
    if (mem_busy) begin
      if (ack_s) mem_busy = 0;
      else mem_left--;
    end
    if (!rst && bus.imem_req) begin
      mem_busy = 1;
      mem_left = mem_lat;
      mem_addr = bus.imem_addr;
    end
  end

  // Leaves the bench at the start of the first cycle with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL reset_outs: req=%0b valid=%0b expected 0/0", bus.imem_req, bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0 || bus.imem_addr !== 64'h0) $display("FAIL reset_vals: pc=%h instr=%h addr=%h expected 0", bus.out_pc, bus.out_instr, bus.imem_addr);
      else n_pass++;
    end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      #2;
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'(4 * c)) $display("FAIL stream_req: c=%0d req=%0b addr=%h expected 1/%h", c, bus.imem_req, bus.imem_addr, 64'(4 * c));
      else n_pass++;
      n_checks++;
      if (c >= 2) begin
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * (c - 2)) || bus.out_instr !== (32'(4 * (c - 2)) | 32'hA000_0000))
          $display("FAIL stream_out: c=%0d valid=%0b pc=%h instr=%h expected pc=%h", c, bus.out_valid, bus.out_pc, bus.out_instr, 64'(4 * (c - 2)));
        else n_pass++;
      end else begin
        if (bus.out_valid !== 1'b0) $display("FAIL stream_early: c=%0d valid=%0b expected 0", c, bus.out_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_full();
    mem_lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    repeat (2) begin
      #2;
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h10) $display("FAIL full_stall: req=%0b addr=%h expected 0/10", bus.imem_req, bus.imem_addr);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) $display("FAIL full_head: valid=%0b pc=%h expected 1/0", bus.out_valid, bus.out_pc);
      else n_pass++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #2;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10) $display("FAIL full_reissue: req=%0b addr=%h expected 1/10", bus.imem_req, bus.imem_addr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #2;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i)) $display("FAIL full_drain: i=%0d valid=%0b pc=%h expected 1/%h", i, bus.out_valid, bus.out_pc, 64'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    mem_lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.imem_req && bus.imem_addr == 64'h8) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL drop_setup: no request for pc 8 seen, got %0b expected 1", found);
    else n_pass++;
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_addr = 64'h103;
    #2;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL drop_redir_cycle: req=%0b valid=%0b expected 0/0", bus.imem_req, bus.out_valid);
    else n_pass++;
    @(negedge clk);
    bus.redirect = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      if (bus.imem_req) found = 1;
    end
    n_checks++;
    if (!found || bus.imem_addr !== 64'h100) $display("FAIL drop_refetch: seen=%0b addr=%h expected 1/100", found, bus.imem_addr);
    else n_pass++;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) found = 1;
    end
    n_checks++;
    if (!found || bus.out_pc !== 64'h100) $display("FAIL drop_first_out: seen=%0b pc=%h expected 1/100", found, bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_ack();
    mem_lat = 2;
    bus.out_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_addr = 64'h100;
    #2;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL rack_cycle: req=%0b valid=%0b expected 0/0", bus.imem_req, bus.out_valid);
    else n_pass++;
    @(negedge clk);
    bus.redirect = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rack_no_push: valid=%0b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) $display("FAIL rack_refetch: req=%0b addr=%h expected 1/100", bus.imem_req, bus.imem_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100) $display("FAIL rack_out: valid=%0b pc=%h expected 1/100", bus.out_valid, bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_full_redirect();
    mem_lat = 1;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (7) @(negedge clk);
    bus.out_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_addr = 64'h200;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL fullredir_cycle: valid=%0b req=%0b expected 0/0", bus.out_valid, bus.imem_req);
    else n_pass++;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL fullredir_count: valid=%0b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) $display("FAIL fullredir_req: req=%0b addr=%h expected 1/200", bus.imem_req, bus.imem_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200) $display("FAIL fullredir_out: valid=%0b pc=%h expected 1/200", bus.out_valid, bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    mem_lat = 3;
    bus.out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || bus.out_valid !== 1'b0) $display("FAIL rstwait_req: req=%0b addr=%h valid=%0b expected 1/0/0", bus.imem_req, bus.imem_addr, bus.out_valid);
    else n_pass++;
    @(negedge clk);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rstwait_ignored: valid=%0b expected 0", bus.out_valid);
    else n_pass++;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'hA000_0000) $display("FAIL rstwait_out: valid=%0b pc=%h instr=%h expected 1/0/a0000000", bus.out_valid, bus.out_pc, bus.out_instr);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_addr = 64'h0;
    bus.out_ready = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_ack();
    test_full_redirect();
    test_reset_in_wait();
    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
